// File: rtl/lcd_read_cycle_if.sv
// Bus bundle between a read requester/panel model and the HD44780 read-cycle sequencer.
// The slave modport is the sequencer side; master is the requester and panel side.
interface lcd_read_cycle_if;
  logic       rd_enable;
  logic       reg_sel;
  logic       poll;
  logic [7:0] db_in;
  logic       e_out;
  logic       rs_out;
  logic       rw_out;
  logic       db_release;
  logic       rd_finish;
  logic [7:0] data_out;
  logic       busy;
  logic [6:0] addr;
  logic       poll_timeout;

  modport master (
    output rd_enable, reg_sel, poll, db_in,
    input  e_out, rs_out, rw_out, db_release, rd_finish, data_out, busy, addr, poll_timeout
  );

  modport slave (
    input  rd_enable, reg_sel, poll, db_in,
    output e_out, rs_out, rw_out, db_release, rd_finish, data_out, busy, addr, poll_timeout
  );
endinterface

// File: rtl/lcd_read_cycle.sv
// HD44780 read-cycle sequencer: single BF/AC or data-RAM reads, or busy-poll until BF clears.
// Optional macro LCD_POLL_TIMEOUT_EN bounds a poll to POLL_MAX reads and flags poll_timeout.
module lcd_read_cycle #(
  parameter int unsigned T_SETUP  = 1,
  parameter int unsigned T_E      = 2,
  parameter int unsigned T_HOLD   = 1,
  parameter int unsigned POLL_MAX = 255
) (
  input logic             clk,
  input logic             rst,
  lcd_read_cycle_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StSetup, StEhigh, StHold, StDone} state_e;

  localparam int unsigned PollBits = $clog2(POLL_MAX + 1);
  localparam int unsigned PollW    = (PollBits < 8) ? 8 : PollBits;

  localparam logic [7:0]       SetupLast = 8'(T_SETUP - 1);
  localparam logic [7:0]       ELast     = 8'(T_E - 1);
  localparam logic [7:0]       HoldLast  = 8'(T_HOLD - 1);
  localparam logic [PollW-1:0] PollMaxW  = PollW'(POLL_MAX);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic             poll_q, poll_d;
  logic [7:0]       data_q, data_d;
  logic [PollW-1:0] poll_cnt_q, poll_cnt_d;
  logic [PollW-1:0] reads_done;
`ifdef LCD_POLL_TIMEOUT_EN
  logic             timeout_q, timeout_d;
`endif

  // Completed reads including the one in HOLD; saturates so it never wraps in unbounded polls.
  assign reads_done = (poll_cnt_q == PollMaxW) ? poll_cnt_q : poll_cnt_q + PollW'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rs_d       = rs_q;
    poll_d     = poll_q;
    data_d     = data_q;
    poll_cnt_d = poll_cnt_q;
`ifdef LCD_POLL_TIMEOUT_EN
    timeout_d  = timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.rd_enable) begin
          rs_d       = bus.reg_sel;
          poll_d     = bus.poll;
          poll_cnt_d = '0;
          cnt_d      = '0;
`ifdef LCD_POLL_TIMEOUT_EN
          timeout_d  = 1'b0;
`endif
          state_d    = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          cnt_d   = '0;
          state_d = StEhigh;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StEhigh: begin
        if (cnt_q == ELast) begin
          cnt_d   = '0;
          data_d  = bus.db_in;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          cnt_d      = '0;
          poll_cnt_d = reads_done;
          // Poll only applies to BF/AC reads; a data-RAM read with poll set is a single read.
          if (poll_q && !rs_q && data_q[7]) begin
`ifdef LCD_POLL_TIMEOUT_EN
            if (reads_done >= PollMaxW) begin
              timeout_d = 1'b1;
              state_d   = StDone;
            end else begin
              state_d = StSetup;
            end
`else
            state_d = StSetup;
`endif
          end else begin
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode straight from state so an async reset drops E/RW/DB release immediately.
  always_comb begin
    bus.e_out      = 1'b0;
    bus.rs_out     = 1'b0;
    bus.rw_out     = 1'b0;
    bus.db_release = 1'b0;
    bus.rd_finish  = 1'b0;
    unique case (state_q)
      StSetup, StHold: begin
        bus.rs_out     = rs_q;
        bus.rw_out     = 1'b1;
        bus.db_release = 1'b1;
      end
      StEhigh: begin
        bus.e_out      = 1'b1;
        bus.rs_out     = rs_q;
        bus.rw_out     = 1'b1;
        bus.db_release = 1'b1;
      end
      StDone:  bus.rd_finish = 1'b1;
      default: bus.rd_finish = 1'b0;
    endcase
  end

  assign bus.data_out = data_q;
  assign bus.busy     = data_q[7];
  assign bus.addr     = data_q[6:0];
`ifdef LCD_POLL_TIMEOUT_EN
  assign bus.poll_timeout = timeout_q;
`else
  assign bus.poll_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rs_q       <= 1'b0;
      poll_q     <= 1'b0;
      data_q     <= 8'h00;
      poll_cnt_q <= '0;
`ifdef LCD_POLL_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rs_q       <= rs_d;
      poll_q     <= poll_d;
      data_q     <= data_d;
      poll_cnt_q <= poll_cnt_d;
`ifdef LCD_POLL_TIMEOUT_EN
      timeout_q  <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_lcd_read_cycle.sv
// Scoreboard bench for lcd_read_cycle: requests push model results, a negedge monitor checks them.
// A panel model inside the monitor serves queued DB bytes on each E rise.
`timescale 1ns/1ps
module tb_lcd_read_cycle;
  localparam int TSetup = 1;
  localparam int TE     = 2;
  localparam int THold  = 1;
`ifdef LCD_POLL_TIMEOUT_EN
  localparam int PollMax   = 3;
  localparam bit TimeoutOn = 1'b1;
`else
  localparam int PollMax   = 255;
  localparam bit TimeoutOn = 1'b0;
`endif

  typedef logic [7:0] byteq_t[$];
  typedef struct {
    logic [7:0] data;
    int         reads;
    logic       tmo;
    logic       rs;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst;
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  int     rw_rises = 0;
  exp_t   exp_q[$];
  byteq_t resp_q;
  int     rise_log[$];

  lcd_read_cycle_if bus ();

  lcd_read_cycle #(
    .T_SETUP (TSetup),
    .T_E     (TE),
    .T_HOLD  (THold),
    .POLL_MAX(PollMax)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    chk("txn_pending", exp_q.size(), 0);
    if (exp_q.size() != 0) begin
      exp_q.delete();
      resp_q.delete();
    end
  endtask

  // Reference: a poll reads until the first byte with BF clear, bounded by PollMax when enabled.
  task automatic push_expect(input logic rs, input logic pl, input byteq_t resp);
    exp_t e;
    int   k = 0;
    int   n;
    while (k < resp.size() && resp[k][7]) k++;
    e.tmo = 1'b0;
    if (rs || !pl) n = 1;
    else if (TimeoutOn && k >= PollMax) begin
      n     = PollMax;
      e.tmo = 1'b1;
    end else n = k + 1;
    e.data  = resp[n-1];
    e.reads = n;
    e.rs    = rs;
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) resp_q.push_back(resp[i]);
  endtask

  task automatic issue(input logic rs, input logic pl, input byteq_t resp);
    wait_idle();
    push_expect(rs, pl, resp);
    @(negedge clk);
    bus.rd_enable = 1'b1;
    bus.reg_sel   = rs;
    bus.poll      = pl;
    @(negedge clk);
    bus.rd_enable = 1'b0;
    bus.reg_sel   = 1'($urandom);
    bus.poll      = 1'($urandom);
  endtask

  // Monitor, scoreboard checker and panel model.
  initial begin
    logic prev_e, prev_rw, prev_rs, prev_fin, seen_rs;
    int   e_pulses, start_cyc;
    exp_t e;
    prev_e = 0; prev_rw = 0; prev_rs = 0; prev_fin = 0; seen_rs = 0;
    e_pulses = 0; start_cyc = 0;
    bus.db_in = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_e = 0; prev_rw = 0; prev_rs = 0; prev_fin = 0; e_pulses = 0;
      end else begin
        if (bus.e_out && !prev_e) begin
          e_pulses++;
          chk("rs_stable_at_e_rise", int'(bus.rs_out), int'(prev_rs));
          chk("rw_stable_at_e_rise", int'(bus.rw_out), int'(prev_rw));
          bus.db_in = (resp_q.size() != 0) ? resp_q.pop_front() : 8'($urandom);
        end
        if (prev_rw && !bus.rw_out) chk("e_low_at_rw_fall", int'(prev_e | bus.e_out), 0);
        if (bus.rw_out && !prev_rw) begin
          start_cyc = cyc;
          seen_rs   = bus.rs_out;
          rw_rises++;
          rise_log.push_back(cyc);
        end
        chk("db_release_eq_rw", int'(bus.db_release), int'(bus.rw_out));
        if (prev_fin) chk("finish_one_cycle", int'(bus.rd_finish), 0);
        if (bus.rd_finish) begin
          chk("finish_has_expectation", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("data_out", int'(bus.data_out), int'(e.data));
            chk("busy", int'(bus.busy), int'(e.data[7]));
            chk("addr", int'(bus.addr), int'(e.data[6:0]));
            chk("poll_timeout", int'(bus.poll_timeout), int'(e.tmo));
            chk("latency", cyc - start_cyc + 1, e.reads * (TSetup + TE + THold) + 1);
            chk("e_pulses", e_pulses, e.reads);
            chk("rs_during_read", int'(seen_rs), int'(e.rs));
            chk("done_rw_low", int'(bus.rw_out | bus.rs_out | bus.e_out), 0);
          end
          e_pulses = 0;
        end
        prev_e   = bus.e_out;
        prev_rw  = bus.rw_out;
        prev_rs  = bus.rs_out;
        prev_fin = bus.rd_finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    byteq_t r;
    int     n;
    rst = 1'b1;
    bus.rd_enable = 1'b0;
    bus.reg_sel   = 1'b0;
    bus.poll      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", int'({bus.e_out, bus.rs_out, bus.rw_out, bus.db_release, bus.rd_finish}), 0);
    chk("reset_data", int'(bus.data_out), 0);
    chk("reset_timeout", int'(bus.poll_timeout), 0);
    rst = 1'b0;
    @(negedge clk);

    issue(1'b1, 1'b0, '{8'h41});
    issue(1'b0, 1'b1, '{8'hA5, 8'hA5, 8'hA5, 8'h27});
    issue(1'b1, 1'b1, '{8'hFF});
    wait_idle();

    // Reset while E is high: control outputs must drop before the next clock edge.
    issue(1'b1, 1'b0, '{8'h5A});
    for (int i = 0; i < 10 && !bus.e_out; i++) @(negedge clk);
    chk("e_high_before_reset", int'(bus.e_out), 1);
    #2 rst = 1'b1;
    #1;
    chk("reset_async_ctrl", int'({bus.e_out, bus.rw_out, bus.db_release, bus.rs_out}), 0);
    exp_q.delete();
    resp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_clears_data", int'(bus.data_out), 0);
    chk("idle_after_reset", int'({bus.e_out, bus.rw_out, bus.rd_finish}), 0);
    issue(1'b0, 1'b0, '{8'h13});
    wait_idle();

`ifdef LCD_POLL_TIMEOUT_EN
    issue(1'b0, 1'b1, '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80});
    wait_idle();
    repeat (2) @(negedge clk);
    chk("timeout_holds", int'(bus.poll_timeout), 1);
    issue(1'b1, 1'b0, '{8'h33});
    chk("timeout_cleared_on_accept", int'(bus.poll_timeout), 0);
    wait_idle();
`endif

    // rd_enable held high: reads must start 6 cycles apart.
    wait_idle();
    for (int i = 0; i < 3; i++) push_expect(1'b1, 1'b0, '{8'($urandom)});
    n = rw_rises;
    @(negedge clk);
    bus.rd_enable = 1'b1;
    bus.reg_sel   = 1'b1;
    bus.poll      = 1'b0;
    for (int i = 0; i < 100 && rw_rises < n + 3; i++) @(negedge clk);
    bus.rd_enable = 1'b0;
    wait_idle();
    chk("b2b_starts", rw_rises - n, 3);
    if (rise_log.size() >= 3) begin
      chk("b2b_gap1", rise_log[rise_log.size()-2] - rise_log[rise_log.size()-3], 6);
      chk("b2b_gap2", rise_log[rise_log.size()-1] - rise_log[rise_log.size()-2], 6);
    end

    for (int t = 0; t < 40; t++) begin
      r.delete();
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) r.push_back(8'h80 | 8'($urandom));
      r.push_back(8'h7F & 8'($urandom));
      issue(1'($urandom), 1'($urandom), r);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_read_cycle.md
Name: lcd_read_cycle

Overview:
- Read-side counterpart of the LCD write-cycle sequencer: generates HD44780 read bus cycles (RW=1) and captures DB[7:0] from the panel.
- Supports a single read of the busy-flag/address register (RS=0) or data RAM (RS=1).
- Supports a busy-poll mode that repeats BF/AC reads until BF clears.
- Runs on the divided LCD clock beside the write sequencer; the owner of the shared bus muxes e/rs/rw and the DB tristate.

Parameters:
- T_SETUP, 1, cycles with RS/RW valid and E low before E rises (>=1).
- T_E, 2, cycles E held high (>=1).
- T_HOLD, 1, cycles E low with RW still high after E falls (>=1).
- POLL_MAX, 255, maximum reads per poll request; used only with LCD_POLL_TIMEOUT_EN.

Ports:
- clk  in  1  divided LCD clock
- rst  in  1  asynchronous, active-high reset
- rd_enable  in  1  start request, sampled only in IDLE
- reg_sel  in  1  0 = BF/AC register, 1 = data RAM; latched at acceptance
- poll  in  1  1 = repeat until BF=0; honoured only when latched reg_sel=0; latched at acceptance
- db_in  in  8  panel data bus (input side of tristate)
- e_out  out  1  LCD E
- rs_out  out  1  LCD RS
- rw_out  out  1  LCD RW
- db_release  out  1  1 = FPGA must tristate DB drivers
- rd_finish  out  1  one-cycle completion pulse
- data_out  out  8  last captured byte
- busy  out  1  data_out[7]
- addr  out  7  data_out[6:0]
- poll_timeout  out  1  poll aborted at POLL_MAX

Behaviour:
- Reset (async, immediate, including mid-cycle):
  - e_out=0, rs_out=0, rw_out=0, db_release=0, rd_finish=0, data_out=8'h00, poll_timeout=0.
  - Counters cleared; state=IDLE.
- States: IDLE, SETUP, EHIGH, HOLD, DONE.
- IDLE:
  - All control outputs 0.
  - rd_enable=1 at a clock edge: latch reg_sel and poll, clear poll counter, clear poll_timeout, go to SETUP.
- SETUP, T_SETUP cycles: rs_out=latched reg_sel, rw_out=1, db_release=1, e_out=0.
- EHIGH, T_E cycles:
  - e_out=1, rs/rw/db_release unchanged.
  - db_in captured into data_out at the edge that leaves EHIGH (last E-high cycle).
- HOLD, T_HOLD cycles: e_out=0, rw_out=1, db_release=1. On exit:
  - Poll active and data_out[7]=1: increment poll counter, re-enter SETUP. RS/RW stay stable; no IDLE gap.
  - Otherwise: go to DONE.
- DONE, 1 cycle:
  - rd_finish=1; rw_out=0, db_release=0, rs_out=0; then IDLE.
  - rd_enable is ignored during DONE. The earliest next acceptance is the IDLE cycle that follows, giving one IDLE cycle minimum between reads.
- Latency, single read: acceptance edge = cycle 0; rd_finish is high in cycle T_SETUP+T_E+T_HOLD+1 (=5 with defaults).
- A poll of N reads completes at N*(T_SETUP+T_E+T_HOLD)+1.
- Holding of results:
  - data_out, busy and addr hold their value until the next capture; they are not cleared in IDLE.
  - busy and addr are meaningful only after a reg_sel=0 read.
- poll=1 with reg_sel=1: single read; poll is ignored.
- Protocol invariants:
  - e_out never rises in the same cycle that rw_out or rs_out changes.
  - rw_out never falls while e_out=1.

Optional Feature:
- Macro: LCD_POLL_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit-or-wider poll counter counts completed reads.
  - If a read with BF=1 completes and the counter has reached POLL_MAX, go to DONE instead of SETUP and assert poll_timeout=1.
  - poll_timeout holds until the next acceptance or reset; rd_finish pulses as normal.
- Without the macro: polling is unbounded, poll_timeout is tied 0, and POLL_MAX is unused.

Test Plan:
- Single data read: reg_sel=1, db_in=8'h41, pulse rd_enable.
  - rs_out=1, rw_out=1 for 4 cycles; e_out high in cycles 2-3.
  - rd_finish high in cycle 5; data_out=8'h41.
- Busy poll: reg_sel=0, poll=1; db_in=8'hA5 for the first 3 reads, then 8'h27.
  - Exactly 4 E pulses; rd_finish in cycle 17.
  - busy=0, addr=7'h27.
- Timeout (macro on, POLL_MAX=3): poll with db_in stuck at 8'h80.
  - 3 E pulses, then rd_finish with poll_timeout=1 and data_out=8'h80.
  - Next acceptance clears poll_timeout.
- Reset mid-EHIGH: assert rst while e_out=1.
  - e_out, rw_out and db_release drop before the next edge.
  - After release: state=IDLE, data_out=8'h00.
- Back-to-back: rd_enable held high continuously.
  - Reads start at cycles 0, 6, 12; one IDLE cycle between them.
  - rd_enable asserted during DONE never shortens the gap.
- Poll ignored: reg_sel=1, poll=1, db_in=8'hFF.
  - Single read; rd_finish in cycle 5; busy=1, reported only.
